// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake, registered outputs and an
// iterative shifter that moves STEP bits per cycle for sll/srl.
//
// state | meaning
// IDLE  | no result pending, ready for a request
// SHIFT | shift in progress, cnt_q bits still to go
// HOLD  | result presented on outputs until consumed
module alu_ctrl_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         gout,
  output logic               is_shift,
  output logic [DATA_W-1:0]  shift_res,
  output logic               illegal
);

  // Wide enough to hold both the counter and STEP, which may equal DATA_W.
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [2:0]         gout_q, gout_d;
  logic               is_shift_q, is_shift_d;
  logic               illegal_q, illegal_d;

  logic [2:0]         dec_code;
  logic               dec_shift;
  logic               dec_illegal;
  logic               accept;
  logic [CW-1:0]      cnt_ext;
  logic [CW-1:0]      step_amt;

  // Decode aluop/funct into the ALU control code; unknown funct falls back to add.
  always_comb begin
    dec_code    = 3'b010;
    dec_shift   = 1'b0;
    dec_illegal = 1'b0;
    if (aluop != 2'b00) begin
      case (funct)
        6'b100000: dec_code = 3'b010;
        6'b100010: dec_code = 3'b110;
        6'b100100: dec_code = 3'b000;
        6'b100101: dec_code = 3'b001;
        6'b101010: dec_code = 3'b111;
        6'b000000: begin
          if (aluop == 2'b10) begin
            dec_code  = 3'b101;
            dec_shift = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'b000010: begin
          if (aluop == 2'b10) begin
            dec_code  = 3'b100;
            dec_shift = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      gout_q     <= '0;
      is_shift_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      gout_q     <= gout_d;
      is_shift_q <= is_shift_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next state: load on accept, shift min(STEP, cnt) per cycle, release on consume.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    gout_d     = gout_q;
    is_shift_d = is_shift_q;
    illegal_d  = illegal_q;
    accept     = in_valid && in_ready;
    cnt_ext    = CW'(cnt_q);
    step_amt   = (cnt_ext < STEP_C) ? cnt_ext : STEP_C;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          gout_d     = dec_code;
          is_shift_d = dec_shift;
          illegal_d  = dec_illegal;
          if (dec_shift && (shamt != '0)) begin
            state_d = S_SHIFT;
            sh_d    = a;
            cnt_d   = shamt;
          end else begin
            state_d = S_HOLD;
            sh_d    = dec_shift ? a : '0;
            cnt_d   = '0;
          end
        end else if (state_q == S_HOLD && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // sll is the only left shift; srl is the only other shift code.
        sh_d  = (gout_q == 3'b101) ? (sh_q << step_amt) : (sh_q >> step_amt);
        cnt_d = cnt_q - SHAMT_W'(step_amt);
        if (cnt_ext <= STEP_C) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs from the current state.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    out_valid = (state_q == S_HOLD);
  end

  assign gout      = gout_q;
  assign is_shift  = is_shift_q;
  assign shift_res = sh_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: one instance with STEP=1 and one with
// STEP=4 share the data inputs but have their own in_valid.
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic [2:0]  g;
    logic        sh;
    logic [31:0] r;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid1, in_valid4;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic        out_ready;

  logic        in_ready1, out_valid1, is_shift1, illegal1;
  logic [2:0]  gout1;
  logic [31:0] shift_res1;
  logic        in_ready4, out_valid4, is_shift4, illegal4;
  logic [2:0]  gout4;
  logic [31:0] shift_res4;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .aluop(aluop), .funct(funct), .shamt(shamt), .a(a),
    .out_valid(out_valid1), .out_ready(out_ready), .gout(gout1),
    .is_shift(is_shift1), .shift_res(shift_res1), .illegal(illegal1)
  );

  alu_ctrl_seq #(.DATA_W(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .aluop(aluop), .funct(funct), .shamt(shamt), .a(a),
    .out_valid(out_valid4), .out_ready(out_ready), .gout(gout4),
    .is_shift(is_shift4), .shift_res(shift_res4), .illegal(illegal4)
  );

  // Reference decode written straight from the opcode table.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [4:0] k, input logic [31:0] x);
    exp_t m;
    m.g = 3'b010; m.sh = 1'b0; m.r = 32'h0; m.ill = 1'b0;
    if (op != 2'b00) begin
      if      (f == 6'b100000) m.g = 3'b010;
      else if (f == 6'b100010) m.g = 3'b110;
      else if (f == 6'b100100) m.g = 3'b000;
      else if (f == 6'b100101) m.g = 3'b001;
      else if (f == 6'b101010) m.g = 3'b111;
      else if (op == 2'b10 && f == 6'b000000) begin m.g = 3'b101; m.sh = 1'b1; m.r = x << k; end
      else if (op == 2'b10 && f == 6'b000010) begin m.g = 3'b100; m.sh = 1'b1; m.r = x >> k; end
      else m.ill = 1'b1;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid1 = 1'b1; in_valid4 = 1'b1; out_ready = 1'b1;
    aluop = 2'b10; funct = 6'b000000; shamt = 5'd3; a = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if ({out_valid1, gout1, is_shift1, shift_res1, illegal1} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs_step1: got %h expected 0", {out_valid1, gout1, is_shift1, shift_res1, illegal1});
    end
    checks++; if ({out_valid4, gout4, is_shift4, shift_res4, illegal4} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs_step4: got %h expected 0", {out_valid4, gout4, is_shift4, shift_res4, illegal4});
    end
    rst_n = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0;
    #1;
    checks++; if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready1);
    end
    tick();
    checks++; if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: got %b%b expected 00", out_valid1, out_valid4);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ftab [5];
    logic [2:0] gtab [5];
    ftab = '{6'b100000, 6'b100010, 6'b101010, 6'b100100, 6'b100101};
    gtab = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b001};
    out_ready = 1'b1; aluop = 2'b10; shamt = 5'd0; a = 32'h0;
    for (int i = 0; i < 5; i++) begin
      funct = ftab[i]; in_valid1 = 1'b1;
      q.push_back('{g: gtab[i], sh: 1'b0, r: 32'h0, ill: 1'b0});
      tick();
      e = q.pop_front();
      checks++; if (out_valid1 !== 1'b1 || gout1 !== e.g || illegal1 !== e.ill || is_shift1 !== e.sh) begin
        errors++; $display("FAIL b2b_decode[%0d]: got v=%b g=%b ill=%b sh=%b expected v=1 g=%b ill=%b sh=%b",
                           i, out_valid1, gout1, illegal1, is_shift1, e.g, e.ill, e.sh);
      end
      checks++; if (in_ready1 !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready1);
      end
    end
    in_valid1 = 1'b0;
    tick();
    checks++; if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid1);
    end
  endtask

  task automatic test_sll_step1();
    int n;
    out_ready = 1'b1; aluop = 2'b10; funct = 6'b000000; shamt = 5'd5; a = 32'h0000_0003;
    in_valid1 = 1'b1;
    q.push_back('{g: 3'b101, sh: 1'b1, r: 32'h0000_0060, ill: 1'b0});
    tick();
    in_valid1 = 1'b0;
    n = 1;
    while (out_valid1 !== 1'b1 && n < 40) begin
      checks++; if (in_ready1 !== 1'b0) begin
        errors++; $display("FAIL sll_busy_in_ready: got %b expected 0 at edge %0d", in_ready1, n);
      end
      tick(); n++;
    end
    e = q.pop_front();
    checks++; if (n !== 6) begin
      errors++; $display("FAIL sll_latency: got %0d edges expected 6 (accept + 5)", n);
    end
    checks++; if (gout1 !== e.g || is_shift1 !== e.sh || shift_res1 !== e.r || illegal1 !== e.ill) begin
      errors++; $display("FAIL sll_result: got g=%b sh=%b r=%h ill=%b expected g=%b sh=%b r=%h ill=%b",
                         gout1, is_shift1, shift_res1, illegal1, e.g, e.sh, e.r, e.ill);
    end
  endtask

  task automatic test_srl_step4();
    int n;
    out_ready = 1'b1; aluop = 2'b10; funct = 6'b000010; shamt = 5'd31; a = 32'h8000_0000;
    in_valid4 = 1'b1;
    q.push_back('{g: 3'b100, sh: 1'b1, r: 32'h0000_0001, ill: 1'b0});
    tick();
    in_valid4 = 1'b0;
    n = 1;
    while (out_valid4 !== 1'b1 && n < 40) begin tick(); n++; end
    e = q.pop_front();
    checks++; if (n !== 9) begin
      errors++; $display("FAIL srl31_latency: got %0d edges expected 9 (accept + 8)", n);
    end
    checks++; if (gout4 !== e.g || is_shift4 !== e.sh || shift_res4 !== e.r) begin
      errors++; $display("FAIL srl31_result: got g=%b sh=%b r=%h expected g=%b sh=%b r=%h",
                         gout4, is_shift4, shift_res4, e.g, e.sh, e.r);
    end
    shamt = 5'd0; a = 32'h1234_5678; in_valid4 = 1'b1;
    q.push_back('{g: 3'b100, sh: 1'b1, r: 32'h1234_5678, ill: 1'b0});
    tick();
    in_valid4 = 1'b0;
    e = q.pop_front();
    checks++; if (out_valid4 !== 1'b1 || gout4 !== e.g || is_shift4 !== e.sh || shift_res4 !== e.r) begin
      errors++; $display("FAIL srl0_result: got v=%b g=%b sh=%b r=%h expected v=1 g=%b sh=%b r=%h",
                         out_valid4, gout4, is_shift4, shift_res4, e.g, e.sh, e.r);
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t old;
    out_ready = 1'b0; aluop = 2'b10; funct = 6'b100010; shamt = 5'd0; a = 32'h0;
    in_valid1 = 1'b1;
    q.push_back(model(aluop, funct, shamt, a));
    tick();
    funct = 6'b100101;
    old = q.pop_front();
    checks++; if (out_valid1 !== 1'b1 || gout1 !== old.g) begin
      errors++; $display("FAIL bp_first: got v=%b g=%b expected v=1 g=%b", out_valid1, gout1, old.g);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid1 !== 1'b1 || gout1 !== old.g || illegal1 !== old.ill || in_ready1 !== 1'b0) begin
        errors++; $display("FAIL bp_stall[%0d]: got v=%b g=%b ill=%b rdy=%b expected v=1 g=%b ill=%b rdy=0",
                           i, out_valid1, gout1, illegal1, in_ready1, old.g, old.ill);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready1);
    end
    q.push_back(model(aluop, funct, shamt, a));
    tick();
    in_valid1 = 1'b0;
    e = q.pop_front();
    checks++; if (out_valid1 !== 1'b1 || gout1 !== e.g) begin
      errors++; $display("FAIL bp_no_bubble: got v=%b g=%b expected v=1 g=%b", out_valid1, gout1, e.g);
    end
    tick();
    checks++; if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid1);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] otab [5];
    logic [5:0] ftab [5];
    otab = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
    ftab = '{6'b000000, 6'b111111, 6'b101010, 6'b111111, 6'b000010};
    out_ready = 1'b1; shamt = 5'd7; a = 32'hA5A5_0F0F;
    for (int i = 0; i < 5; i++) begin
      aluop = otab[i]; funct = ftab[i]; in_valid1 = 1'b1;
      q.push_back(model(aluop, funct, shamt, a));
      tick();
      e = q.pop_front();
      checks++; if (out_valid1 !== 1'b1 || gout1 !== e.g || illegal1 !== e.ill || is_shift1 !== e.sh || shift_res1 !== e.r) begin
        errors++; $display("FAIL illegal_decode[%0d]: got v=%b g=%b ill=%b sh=%b r=%h expected v=1 g=%b ill=%b sh=%b r=%h",
                           i, out_valid1, gout1, illegal1, is_shift1, shift_res1, e.g, e.ill, e.sh, e.r);
      end
    end
    in_valid1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    out_ready = 1'b1; aluop = 2'b10; funct = 6'b000000; shamt = 5'd20; a = 32'hDEAD_BEEF;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick(); tick();
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL abort_mid_shift: got v=%b rdy=%b expected v=0 rdy=0", out_valid1, in_ready1);
    end
    rst_n = 1'b0;
    tick();
    checks++; if ({out_valid1, gout1, is_shift1, shift_res1, illegal1} !== 38'h0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL abort_outputs: got %h rdy=%b expected 0 rdy=1",
                         {out_valid1, gout1, is_shift1, shift_res1, illegal1}, in_ready1);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid1 === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_random_step4();
    logic [5:0] fsel [8];
    int n, exp_n;
    fsel = '{6'b000000, 6'b000010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      aluop = 2'($urandom_range(0, 3));
      funct = ($urandom_range(0, 9) < 8) ? fsel[$urandom_range(0, 7)] : 6'($urandom);
      shamt = 5'($urandom);
      a     = $urandom;
      e = model(aluop, funct, shamt, a);
      exp_n = (e.sh && shamt != 5'd0) ? 1 + (int'(shamt) + 3) / 4 : 1;
      in_valid4 = 1'b1;
      q.push_back(e);
      tick();
      in_valid4 = 1'b0;
      n = 1;
      while (out_valid4 !== 1'b1 && n < 40) begin tick(); n++; end
      e = q.pop_front();
      checks++; if (n !== exp_n || gout4 !== e.g || is_shift4 !== e.sh || shift_res4 !== e.r || illegal4 !== e.ill) begin
        errors++; $display("FAIL rand4[%0d] op=%b f=%b k=%0d: got n=%0d g=%b sh=%b r=%h ill=%b expected n=%0d g=%b sh=%b r=%h ill=%b",
                           t, aluop, funct, shamt, n, gout4, is_shift4, shift_res4, illegal4,
                           exp_n, e.g, e.sh, e.r, e.ill);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sll_step1();
    test_srl_step4();
    test_backpressure();
    test_illegal();
    test_reset_abort();
    test_random_step4();
    checks++; if (q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised successor to the combinational ALU control decoder. It decodes `aluop`/`funct` into the 3-bit ALU control code with a valid/ready handshake and a registered output, and adds `srl` alongside `sll`. Shifts run on a built-in iterative shifter (`STEP` bits per cycle), so the datapath no longer needs a barrel shifter. It sits between the main control unit and the ALU/shift writeback mux of the multi-cycle core.

## Interface
- `DATA_W`, 32: operand and shift-result width.
- `SHAMT_W`, 5: shift-amount width; requires 2^SHAMT_W ≤ DATA_W.
- `STEP`, 1: bits shifted per cycle; power of two, 1 ≤ STEP ≤ DATA_W.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `aluop`  in  2  ALU operation class from main control.
- `funct`  in  6  instruction function field.
- `shamt`  in  SHAMT_W  shift amount.
- `a`  in  DATA_W  shift operand (rt value).
- `out_valid`  out  1  result valid; held until it is consumed.
- `out_ready`  in  1  consumer accepts the result.
- `gout`  out  3  ALU control code.
- `is_shift`  out  1  result is a shift; `shift_res` is meaningful.
- `shift_res`  out  DATA_W  shifted operand.
- `illegal`  out  1  unrecognised `funct` for the given `aluop`.

## Operation
- Codes: and 000, or 001, add 010, srl 100, sll 101, sub 110, slt 111.
- `aluop`=00 (lw/sw): `gout`=010. `funct` is ignored.
- `aluop`=01 or 11: decode `funct`:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
- `aluop`=10 (R-type): the same table, plus 000000 → sll (101) and 000010 → srl (100).
- Any other `funct`: `gout`=010, `illegal`=1. The previous code is never held.
- A request is accepted on an edge where `in_valid && in_ready`.
- States: IDLE, SHIFT, HOLD.
  - IDLE → HOLD: non-shift op, or shift with `shamt`=0. Outputs are loaded at the accept edge; `shift_res`=`a` when the op is a shift, else 0.
  - IDLE → SHIFT: shift with `shamt`=k>0. Loads `a` into the shift register and k into the counter. `gout` and `is_shift`=1 are loaded at the same edge.
  - SHIFT: each edge shifts by min(STEP, cnt) and subtracts that amount from `cnt`. Direction: sll shifts left with zero fill; srl shifts right with zero fill.
  - SHIFT → HOLD: on the edge where cnt ≤ STEP. `out_valid` rises at that same edge.
  - HOLD: outputs are stable while `out_ready`=0. On `out_ready`=1, go to IDLE, or accept a new request in the same cycle.
- `in_ready` = (state==IDLE) || (state==HOLD && `out_ready`). This is combinational from state and `out_ready`.
- `out_valid` = (state==HOLD).
- `in_valid` while `in_ready`=0 is ignored. Inputs are sampled only at the accept edge.

## Timing
- Reset edge (`rst_n`=0): state=IDLE, cnt=0. `out_valid`, `gout`, `is_shift`, `shift_res`, `illegal` all 0. `in_ready`=1 from the first cycle after reset.
- Reset mid-SHIFT or in HOLD: the operation is abandoned. No `out_valid` pulse; outputs are 0 after the edge.
- Accept at edge N, non-shift or k=0: `out_valid`=1 after edge N (latency 1).
- Accept at edge N, shift with k>0: `out_valid`=1 after edge N+ceil(k/STEP).
- Throughput with `out_ready` tied high: one non-shift op per cycle. A shift occupies the block for 1+ceil(k/STEP) cycles.
- Maximum k = 2^SHAMT_W−1. The counter never wraps: it stops at 0 and the final step is partial.
- Simultaneous consume + accept in HOLD: the new op's outputs replace the old ones at the same edge. There is no bubble.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → all outputs 0, no accept. `in_ready`=1 on the first cycle after release.
- Back-to-back decode, `out_ready`=1, `aluop`=10, `funct`=100000, 100010, 101010, 100100, 100101 on consecutive cycles → `gout`=010, 110, 111, 000, 001 on consecutive cycles. `illegal`=0. `in_ready` stays 1.
- `aluop`=10, `funct`=000000, `shamt`=5, `a`=0x0000_0003, STEP=1 → `out_valid` 5 edges after accept. `gout`=101, `shift_res`=0x0000_0060. `in_ready`=0 during SHIFT.
- `aluop`=10, `funct`=000010, `shamt`=31, `a`=0x8000_0000, STEP=4 → done after 8 edges, `shift_res`=0x0000_0001, `gout`=100. Also `shamt`=0 → latency 1, `shift_res`=`a`.
- Backpressure: `out_ready`=0 for 3 cycles after `out_valid` → outputs stable and `in_ready`=0. Raise `out_ready` together with a new `in_valid` → the new op is accepted on that edge with no idle cycle.
- Illegal and reset abort: `aluop`=01, `funct`=000000 → `gout`=010, `illegal`=1, `is_shift`=0. Start `shamt`=20 sll, assert `rst_n`=0 at the 3rd SHIFT edge → no `out_valid`, outputs 0, IDLE.
